// File: rtl/b11_pkg.sv
// Shared definitions for the b11 scrambler-core scheduler.
// Holds the FSM state encoding, the default sizes and the timer width.
package b11_pkg;
    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 64;
    localparam int TIMER_W     = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/b11_sched_rr_arb.sv
// Round-robin pick: the first asserted request at or after ptr, wrapping around.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   index,
    output logic            any
);
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[(int'(ptr) + i) % NREQ]) begin
                any                            = 1'b1;
                grant[(int'(ptr) + i) % NREQ]  = 1'b1;
                index                          = IW'((int'(ptr) + i) % NREQ);
            end
        end
    end
endmodule

// File: rtl/b11_sched.sv
// Arbitrates NREQ requesters onto one shared b11 core, one transaction at a time,
// with a per-transaction timeout that returns an error response.
module b11_sched
    import b11_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [6*NREQ-1:0] din,
    output logic [NREQ-1:0]   gnt,
    output logic              core_start,
    output logic [5:0]        core_din,
    input  logic              core_done,
    input  logic [5:0]        core_dout,
    output logic              resp_valid,
    output logic [1:0]        resp_id,
    output logic              resp_err,
    output logic [5:0]        x_out
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t               state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        idx;
    logic [TIMER_W-1:0]   timer;

    logic [NREQ-1:0]      arb_grant;
    logic [IW-1:0]        arb_index;
    logic                 arb_any;

    rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .index (arb_index),
        .any   (arb_any)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            idx        <= '0;
            timer      <= '0;
            gnt        <= '0;
            core_start <= 1'b0;
            core_din   <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_err   <= 1'b0;
            x_out      <= '0;
        end else begin
            gnt        <= '0;
            core_start <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        gnt      <= arb_grant;
                        idx      <= arb_index;
                        // core_din doubles as the latched operand until the next grant
                        core_din <= din[6*arb_index +: 6];
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    core_start <= 1'b1;
                    timer      <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        x_out    <= core_dout;
                        resp_err <= 1'b0;
                        state    <= S_RESP;
                    end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                        x_out    <= '0;
                        resp_err <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RESP: begin
                    resp_valid <= 1'b1;
                    resp_id    <= 2'(idx);
                    ptr        <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_b11_sched.sv
// Randomized scoreboard bench for b11_sched: a driver issues transactions and queues
// the expected grant/start/response; a monitor pops and compares as the DUT presents them.
module tb_b11_sched;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [23:0] din;
    logic [3:0]  gnt;
    logic        core_start;
    logic [5:0]  core_din;
    logic        core_done;
    logic [5:0]  core_dout;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic        resp_err;
    logic [5:0]  x_out;

    b11_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .req(req), .din(din), .gnt(gnt),
        .core_start(core_start), .core_din(core_din), .core_done(core_done),
        .core_dout(core_dout), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_err(resp_err), .x_out(x_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         id;
        logic       err;
        logic [5:0] x;
        int         lat;
    } resp_t;

    logic [3:0] gq[$];
    logic [5:0] sq[$];
    resp_t      rq[$];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int gcyc   = 0;
    int mptr   = 0;
    logic [5:0] last_x = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (gnt != 0) begin
                if (gq.size() == 0) chk("gnt_unexpected", gnt, 0);
                else chk("gnt", gnt, gq.pop_front());
                gcyc = cyc;
            end
            if (core_start) begin
                if (sq.size() == 0) chk("start_unexpected", core_start, 0);
                else begin
                    chk("core_din", core_din, sq.pop_front());
                    chk("start_lat", cyc - gcyc, 1);
                end
            end
            if (resp_valid) begin
                if (rq.size() == 0) chk("resp_unexpected", resp_valid, 0);
                else begin
                    resp_t e;
                    e = rq.pop_front();
                    chk("resp_id", resp_id, e.id);
                    chk("resp_err", resp_err, e.err);
                    chk("x_out", x_out, e.x);
                    chk("resp_lat", cyc - gcyc, e.lat);
                end
            end
        end
    end

    function automatic int winner(input logic [3:0] r);
        int w = -1;
        for (int i = 0; i < NREQ; i++) begin
            int j = (mptr + i) % NREQ;
            if (w < 0 && r[j]) w = j;
        end
        return w;
    endfunction

    // One transaction starting in an IDLE cycle; d = WAIT cycle on which core_done
    // pulses (beyond TIMEOUT means the core never answers in time).
    task automatic run_txn(input logic [3:0] r, input logic [23:0] dv, input int d,
                           input logic [5:0] dout, input bit hold);
        int w;
        int n;
        resp_t e;
        w = winner(r);
        if (w < 0) return;
        e.id  = w;
        e.err = (d > TIMEOUT);
        e.x   = (d > TIMEOUT) ? 6'h00 : dout;
        e.lat = ((d > TIMEOUT) ? TIMEOUT : d) + 2;
        gq.push_back(4'(1 << w));
        sq.push_back(dv[6*w +: 6]);
        rq.push_back(e);
        req = r;
        din = dv;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (gnt == 0 && n < 8);
        chk("gnt_wait", n, 1);
        if (gnt == 0) begin
            gq.delete(); sq.delete(); rq.delete();
            req = '0;
            return;
        end
        if (!hold) req = '0;
        for (int k = 1; k <= TIMEOUT + 4; k++) begin
            @(posedge clock); #1;
            core_done = 1'b0;
            if (resp_valid) break;
            if (k == d) begin
                core_done = 1'b1;
                core_dout = dout;
            end
        end
        core_done = 1'b0;
        chk("resp_seen", resp_valid, 1);
        mptr   = (w + 1) % NREQ;
        last_x = e.x;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] dv;
        int d;
        reset = 1'b1; req = '0; din = '0; core_done = 1'b0; core_dout = '0;
        @(posedge clock); @(posedge clock); #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_start", core_start, 0);
        chk("rst_core_din", core_din, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_x_out", x_out, 0);
        reset = 1'b0;

        // All requesters held: round-robin order 0,1,2,3,0 in 4-cycle transactions
        for (int t = 0; t < 5; t++)
            run_txn(4'b1111, $urandom, 1, 6'($urandom), 1'b1);
        req = '0;

        // Single requester 1 with operand 05, core answers 12 on WAIT cycle 3
        run_txn(4'b0010, 24'h000140, 3, 6'h12, 1'b0);
        // Timeout, then done coincident with the final timeout cycle
        run_txn(4'b0001, 24'h00003C, 200, 6'h11, 1'b0);
        run_txn(4'b1000, 24'h2A0000, TIMEOUT, 6'h2A, 1'b0);
        // Done arrives one cycle late (in S_RESP) and must be ignored
        run_txn(4'b0100, 24'h015000, TIMEOUT + 1, 6'h33, 1'b0);

        // Spurious core_done while idle
        core_done = 1'b1; core_dout = 6'h3F;
        @(posedge clock); #1;
        core_done = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("spur_x_out", x_out, last_x);
        chk("spur_resp_valid", resp_valid, 0);

        // Advance ptr to 3, then abandon a transaction with reset during S_WAIT
        run_txn(4'b0100, $urandom, 2, 6'($urandom), 1'b0);
        gq.push_back(4'b1000);
        sq.push_back(6'h21);
        req = 4'b1000; din = 24'h840000;
        @(posedge clock); #1;
        req = '0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("wrst_gnt", gnt, 0);
        chk("wrst_start", core_start, 0);
        chk("wrst_core_din", core_din, 0);
        chk("wrst_resp_valid", resp_valid, 0);
        chk("wrst_resp_err", resp_err, 0);
        chk("wrst_x_out", x_out, 0);
        chk("wrst_gq_drained", gq.size(), 0);
        gq.delete(); sq.delete(); rq.delete();
        mptr = 0;
        last_x = '0;
        repeat (4) @(posedge clock);
        #1;
        // ptr back at 0: 0110 must go to requester 1
        run_txn(4'b0110, $urandom, 2, 6'($urandom), 1'b0);
        run_txn(4'b0100, $urandom, 1, 6'($urandom), 1'b0);

        for (int t = 0; t < 30; t++) begin
            dv = $urandom;
            case ($urandom_range(0, 5))
                0:       d = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
                1:       d = 500;
                default: d = $urandom_range(1, 8);
            endcase
            run_txn(4'($urandom_range(1, 15)), dv, d, 6'($urandom), 1'($urandom_range(0, 1)));
            req = '0;
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end

        repeat (4) @(posedge clock);
        #1;
        chk("end_gq_empty", gq.size(), 0);
        chk("end_rq_empty", rq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/b11_sched.md
B11_SCHED -- requirements
Module: b11_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one b11-class scrambler core.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum core cycles waited per transaction.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req, input, NREQ: per-requester request; held high until granted.
REQ-006 SHALL have port din, input, 6*NREQ: requester i data at bits [6i+5:6i].
REQ-007 SHALL have port gnt, output, NREQ: one-hot grant pulse, one cycle wide.
REQ-008 SHALL have port core_start, output, 1: one-cycle start pulse to the shared core.
REQ-009 SHALL have port core_din, output, 6: operand presented to the core.
REQ-010 SHALL have port core_done, input, 1: core result valid, one-cycle pulse.
REQ-011 SHALL have port core_dout, input, 6: core result, valid with core_done.
REQ-012 SHALL have port resp_valid, output, 1: one-cycle response strobe.
REQ-013 SHALL have port resp_id, output, 2: index of the requester being answered.
REQ-014 SHALL have port resp_err, output, 1: response terminated by timeout.
REQ-015 SHALL have port x_out, output, 6: response data.

Function
REQ-016 SHALL implement FSM states S_IDLE, S_ISSUE, S_WAIT, S_RESP; any other encoding goes to S_IDLE next cycle.
REQ-017 S_IDLE: if any req bit is high, SHALL select a winner round-robin starting at pointer ptr, latch its din and index, pulse gnt for the winner, and go to S_ISSUE; otherwise stay.
REQ-018 S_ISSUE: SHALL assert core_start for exactly one cycle with core_din = latched operand, clear the 7-bit timer, and go to S_WAIT.
REQ-019 core_din SHALL hold the latched operand from S_ISSUE through S_RESP.
REQ-020 S_WAIT: on core_done, SHALL capture core_dout into x_out, clear resp_err, and go to S_RESP.
REQ-021 S_WAIT: without core_done, SHALL increment timer; when timer reaches TIMEOUT-1, SHALL set x_out=0, set resp_err=1, and go to S_RESP.
REQ-022 core_done in the same cycle as timeout SHALL win: data captured, resp_err=0.
REQ-023 S_RESP: SHALL pulse resp_valid for one cycle with resp_id = latched index, set ptr = (index+1) mod NREQ, and go to S_IDLE.
REQ-024 x_out, resp_id and resp_err SHALL hold their values until the next response.
REQ-025 core_done outside S_WAIT SHALL be ignored.
REQ-026 A req dropped before grant SHALL NOT be served; req is not sampled outside S_IDLE.
REQ-027 Minimum transaction length SHALL be 4 cycles (IDLE, ISSUE, one WAIT, RESP); a single transaction is outstanding at a time.

Reset
REQ-028 Reset SHALL force S_IDLE, ptr=0, timer=0, and gnt, core_start, core_din, resp_valid, resp_id, resp_err, x_out all to 0 on the next edge.
REQ-029 Reset in any state SHALL abandon the in-flight transaction without a response; core_start SHALL NOT reassert until a new grant.

Structure
REQ-030 State encodings and default NREQ/TIMEOUT values SHALL reside in shared package b11_pkg.
REQ-031 Round-robin selection SHALL be sub-module rr_arb (inputs req and ptr; outputs one-hot grant, index, any).

Verification
REQ-032 Req=4'b0010, din1=6'h05; core_done at WAIT cycle 3 with dout 6'h12 -> gnt=0010 in cycle 1, core_start with core_din=05 in cycle 2, resp_valid with id=1, x_out=12, err=0.
REQ-033 Req=4'b1111 held after reset, core_done after 1 cycle each time -> grants in order 0,1,2,3,0, each transaction 4 cycles.
REQ-034 core_done never asserted -> resp_valid with resp_err=1 and x_out=0 at WAIT cycle 64.
REQ-035 core_done coincident with the final timeout cycle, dout=6'h2A -> resp_err=0, x_out=2A.
REQ-036 Reset asserted during S_WAIT -> no resp_valid, all outputs 0; next req=4'b0100 is granted to requester 2 with ptr=0 behaviour.
REQ-037 Spurious core_done in S_IDLE with dout=6'h3F -> x_out and resp_valid unchanged.
